// File: rtl/microseq_branch_ctrl.sv
// Microcode next-address controller: seq_op + condition flags -> counter cmd/load_addr, with return stack.
// cmd/load_addr are combinational (zero latency); stall freezes all state. MICROSEQ_LOOP_EN adds LDCNT/DJNZ.
package microaddr;
  typedef enum logic [1:0] {
    NONE = 2'd0,
    INC  = 2'd1,
    LOAD = 2'd2
  } cmd;
endpackage

module microseq_branch_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int NCOND       = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     stall_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [3:0]               seq_op_i,
  input  logic [ADDR_W-1:0]        target_i,
  input  logic [$clog2(NCOND)-1:0] cond_sel_i,
  input  logic                     cond_pol_i,
  input  logic [NCOND-1:0]         cond_i,
  input  logic [ADDR_W-1:0]        dispatch_addr_i,
  output microaddr::cmd            cmd_o,
  output logic [ADDR_W-1:0]        load_addr_o,
  output logic                     stack_ovf_o,
  output logic                     stack_unf_o,
  output logic                     bad_op_o
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [3:0] OP_NEXT     = 4'd0;
  localparam logic [3:0] OP_JUMP     = 4'd1;
  localparam logic [3:0] OP_JCOND    = 4'd2;
  localparam logic [3:0] OP_CALL     = 4'd3;
  localparam logic [3:0] OP_RET      = 4'd4;
  localparam logic [3:0] OP_DISPATCH = 4'd5;
  localparam logic [3:0] OP_WAIT     = 4'd6;
  localparam logic [3:0] OP_HALT     = 4'd7;
`ifdef MICROSEQ_LOOP_EN
  localparam logic [3:0] OP_LDCNT    = 4'd8;
  localparam logic [3:0] OP_DJNZ     = 4'd9;
`endif

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stack_ovf_q, stack_ovf_d;
  logic              stack_unf_q, stack_unf_d;
  logic              bad_op_q, bad_op_d;
  logic              push;
  logic [IDX_W-1:0]  push_idx, top_idx;
  logic              cond_hit;
  microaddr::cmd     cmd_d;
  logic [ADDR_W-1:0] load_addr_d;
`ifdef MICROSEQ_LOOP_EN
  logic [7:0]        loop_cnt_q, loop_cnt_d;
`endif

  assign cond_hit = (cond_i[cond_sel_i] == cond_pol_i);
  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    cmd_d       = microaddr::NONE;
    load_addr_d = '0;
    sp_d        = sp_q;
    push        = 1'b0;
    stack_ovf_d = stack_ovf_q;
    stack_unf_d = stack_unf_q;
    bad_op_d    = bad_op_q;
`ifdef MICROSEQ_LOOP_EN
    loop_cnt_d  = loop_cnt_q;
`endif
    if (!stall_i) begin
      case (seq_op_i)
        OP_NEXT:  cmd_d = microaddr::INC;
        OP_JUMP: begin
          cmd_d       = microaddr::LOAD;
          load_addr_d = target_i;
        end
        OP_JCOND: begin
          if (cond_hit) begin
            cmd_d       = microaddr::LOAD;
            load_addr_d = target_i;
          end else begin
            cmd_d = microaddr::INC;
          end
        end
        // A full stack still takes the call; only the return address is lost.
        OP_CALL: begin
          cmd_d       = microaddr::LOAD;
          load_addr_d = target_i;
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            stack_ovf_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
        end
        OP_RET: begin
          cmd_d = microaddr::LOAD;
          if (sp_q == '0) begin
            stack_unf_d = 1'b1;
          end else begin
            load_addr_d = stack_q[top_idx];
            sp_d        = sp_q - SP_W'(1);
          end
        end
        OP_DISPATCH: begin
          cmd_d       = microaddr::LOAD;
          load_addr_d = dispatch_addr_i;
        end
        OP_WAIT:  cmd_d = cond_hit ? microaddr::INC : microaddr::NONE;
        OP_HALT:  cmd_d = microaddr::NONE;
`ifdef MICROSEQ_LOOP_EN
        OP_LDCNT: begin
          cmd_d      = microaddr::INC;
          loop_cnt_d = target_i[7:0];
        end
        OP_DJNZ: begin
          if (loop_cnt_q != 8'd0) begin
            cmd_d       = microaddr::LOAD;
            load_addr_d = target_i;
            loop_cnt_d  = loop_cnt_q - 8'd1;
          end else begin
            cmd_d = microaddr::INC;
          end
        end
`endif
        default:  bad_op_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sp_q        <= '0;
      stack_ovf_q <= 1'b0;
      stack_unf_q <= 1'b0;
      bad_op_q    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`ifdef MICROSEQ_LOOP_EN
      loop_cnt_q  <= 8'd0;
`endif
    end else begin
      sp_q        <= sp_d;
      stack_ovf_q <= stack_ovf_d;
      stack_unf_q <= stack_unf_d;
      bad_op_q    <= bad_op_d;
      if (push) stack_q[push_idx] <= addr_i + ADDR_W'(1);
`ifdef MICROSEQ_LOOP_EN
      loop_cnt_q  <= loop_cnt_d;
`endif
    end
  end

  // Outputs are forced quiet while reset is held, independent of any clock edge.
  assign cmd_o       = reset_i ? microaddr::NONE : cmd_d;
  assign load_addr_o = reset_i ? '0 : load_addr_d;
  assign stack_ovf_o = stack_ovf_q;
  assign stack_unf_o = stack_unf_q;
  assign bad_op_o    = bad_op_q;

endmodule
